// File: rtl/seq_scan_ctrl_if.sv
// Request/result bundle between a CPU-side requester (master) and the
// serial pattern-scan controller (slave).
interface seq_scan_ctrl_if #(
  parameter int DATA_W  = 16,
  parameter int PAT_MAX = 4,
  parameter int CNT_W   = $clog2(DATA_W + 1),
  parameter int POS_W   = $clog2(DATA_W),
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
);
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] in_word;
  logic [PAT_MAX-1:0] cfg_pat;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_ovl;
  logic              ready;
  logic              busy;
  logic              ser_bit;
  logic              match;
  logic              done;
  logic [CNT_W-1:0]  match_cnt;
  logic              any_match;
  logic [POS_W-1:0]  first_pos;

  modport master (
    output start, abort, in_word, cfg_pat, cfg_len, cfg_ovl,
    input  ready, busy, ser_bit, match, done, match_cnt, any_match, first_pos
  );
  modport slave (
    input  start, abort, in_word, cfg_pat, cfg_len, cfg_ovl,
    output ready, busy, ser_bit, match, done, match_cnt, any_match, first_pos
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Scans a captured word MSB-first through a programmable Mealy pattern
// matcher, counting matches and recording the first match position.
module seq_scan_ctrl #(
  parameter int DATA_W  = 16,
  parameter int PAT_MAX = 4,
  parameter int CNT_W   = $clog2(DATA_W + 1),
  parameter int POS_W   = $clog2(DATA_W)
) (
  input  logic clk,
  input  logic rst,
  seq_scan_ctrl_if.slave bus
);
  localparam int LEN_W = $clog2(PAT_MAX + 1);
  localparam logic [LEN_W-1:0] PMAX  = LEN_W'(PAT_MAX);
  localparam logic [POS_W-1:0] K_END = POS_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0]  word_q, word_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [PAT_MAX-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   seen_q, seen_d;
  logic [POS_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               any_q, any_d;
  logic [POS_W-1:0]   first_q, first_d;

  logic               in_scan, ser, hit;
  logic [PAT_MAX-1:0] win, mask;
  logic [LEN_W:0]     seen_p1;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (bus.abort) state_d = IDLE;
               else if (k_q == K_END) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.ready   = (state_q == IDLE);
    bus.busy    = (state_q == SCAN);
    bus.done    = (state_q == DONE);
    bus.ser_bit = ser;
    bus.match   = hit;
  end

  assign bus.match_cnt = cnt_q;
  assign bus.any_match = any_q;
  assign bus.first_pos = first_q;

  // Matcher: the word shifts left each scan cycle so its MSB is the current bit.
  always_comb begin
    in_scan = (state_q == SCAN);
    ser     = in_scan & word_q[DATA_W-1];
    win     = {hist_q, ser};
    seen_p1 = {1'b0, seen_q} + 1'b1;
    for (int i = 0; i < PAT_MAX; i++) mask[i] = (i < int'(len_q));
    hit = in_scan && (len_q != '0) && (seen_p1 >= {1'b0, len_q}) &&
          (((win ^ pat_q) & mask) == '0);
  end

  always_comb begin
    word_d  = word_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    seen_d  = seen_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    any_d   = any_q;
    first_d = first_q;
    if (state_q == IDLE && bus.start) begin
      word_d  = bus.in_word;
      pat_d   = bus.cfg_pat;
      ovl_d   = bus.cfg_ovl;
      len_d   = (bus.cfg_len > PMAX) ? PMAX : bus.cfg_len;
      hist_d  = '0;
      seen_d  = '0;
      k_d     = '0;
      cnt_d   = '0;
      any_d   = 1'b0;
      first_d = '0;
    end else if (in_scan) begin
      word_d = {word_q[DATA_W-2:0], 1'b0};
      hist_d = win[PAT_MAX-2:0];
      k_d    = k_q + 1'b1;
      // non-overlapping mode forgets the matched bits so they cannot be reused
      if (hit && !ovl_q)       seen_d = '0;
      else if (seen_q != PMAX) seen_d = seen_q + 1'b1;
      if (hit) begin
        cnt_d = cnt_q + 1'b1;
        if (!any_q) begin
          first_d = k_q;
          any_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      seen_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      any_q   <= 1'b0;
      first_q <= '0;
    end else begin
      word_q  <= word_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      any_q   <= any_d;
      first_q <= first_d;
    end
  end
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: hand-computed match positions per scan,
// abort, ignored restart, async reset and length clamping.
module tb_seq_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl_if #(.DATA_W(16), .PAT_MAX(4)) bus ();
  seq_scan_ctrl #(.DATA_W(16), .PAT_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // em[k] = 1 where a match is expected at scan index k
  task automatic run(input logic [15:0] w, input logic [3:0] p, input logic [2:0] l,
                     input logic o, input logic [15:0] em, input int ecnt,
                     input logic eany, input int efirst, input int glitch_k,
                     input int abort_k);
    @(negedge clk);
    bus.in_word = w; bus.cfg_pat = p; bus.cfg_len = l; bus.cfg_ovl = o;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == glitch_k) begin
        bus.start = 1'b1; bus.in_word = ~w; bus.cfg_pat = ~p; bus.cfg_len = 3'd0;
      end else begin
        bus.start = 1'b0;
      end
      chk("busy", 32'(bus.busy), 32'd1);
      chk("ser_bit", 32'(bus.ser_bit), 32'(w[15-k]));
      chk($sformatf("match k=%0d", k), 32'(bus.match), 32'(em[k]));
      if (k == abort_k) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort ready", 32'(bus.ready), 32'd1);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort cnt", 32'(bus.match_cnt), 32'(ecnt));
        chk("abort first", 32'(bus.first_pos), 32'(efirst));
        @(negedge clk);
        chk("abort no done", 32'(bus.done), 32'd0);
        return;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done", 32'(bus.done), 32'd1);
    chk("done ready", 32'(bus.ready), 32'd0);
    chk("cnt", 32'(bus.match_cnt), 32'(ecnt));
    chk("any", 32'(bus.any_match), 32'(eany));
    chk("first", 32'(bus.first_pos), 32'(efirst));
    @(negedge clk);
    chk("ready after", 32'(bus.ready), 32'd1);
    chk("done pulse", 32'(bus.done), 32'd0);
    chk("cnt hold", 32'(bus.match_cnt), 32'(ecnt));
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_word = '0;
    bus.cfg_pat = '0; bus.cfg_len = '0; bus.cfg_ovl = 1'b0;
    #12;
    chk("rst ready", 32'(bus.ready), 32'd1);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst cnt", 32'(bus.match_cnt), 32'd0);
    chk("rst any", 32'(bus.any_match), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // overlapping: matches at k=2,4,15
    run(16'b1010_1000_0000_0101, 4'b0101, 3'd3, 1'b1, 16'h8014, 3, 1'b1, 2, -1, -1);
    // non-overlapping: k=4 suppressed
    run(16'b1010_1000_0000_0101, 4'b0101, 3'd3, 1'b0, 16'h8004, 2, 1'b1, 2, -1, -1);
    run(16'hFFFF, 4'b0001, 3'd1, 1'b1, 16'hFFFF, 16, 1'b1, 0, -1, -1);
    run(16'hFFFF, 4'b0001, 3'd0, 1'b1, 16'h0000, 0, 1'b0, 0, -1, -1);
    // abort at k=5 after matches at k=2,4
    run(16'b1010_1000_0000_0101, 4'b0101, 3'd3, 1'b1, 16'h8014, 2, 1'b1, 2, -1, 5);
    // start pulse at k=3 mid-scan must be ignored
    run(16'b1010_1000_0000_0101, 4'b0101, 3'd3, 1'b1, 16'h8014, 3, 1'b1, 2, 3, -1);
    // length clamp 7 -> 4
    run(16'hF000, 4'b1111, 3'd7, 1'b1, 16'h0008, 1, 1'b1, 3, -1, -1);

    // async reset at k=8
    @(negedge clk);
    bus.in_word = 16'b1010_1000_0000_0101; bus.cfg_pat = 4'b0101;
    bus.cfg_len = 3'd3; bus.cfg_ovl = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre-rst cnt", 32'(bus.match_cnt), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst ready", 32'(bus.ready), 32'd1);
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst done", 32'(bus.done), 32'd0);
    chk("arst ser", 32'(bus.ser_bit), 32'd0);
    chk("arst match", 32'(bus.match), 32'd0);
    chk("arst cnt", 32'(bus.match_cnt), 32'd0);
    chk("arst any", 32'(bus.any_match), 32'd0);
    chk("arst first", 32'(bus.first_pos), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(16'b1010_1000_0000_0101, 4'b0101, 3'd3, 1'b1, 16'h8014, 3, 1'b1, 2, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Controller that sequences a serial bit-pattern detector over a parallel data word. On a start handshake it captures a DATA_W-bit word and a pattern configuration, then presents the word MSB-first, one bit per clock, to an internal programmable Mealy-style pattern matcher. It counts matches, records the position of the first match, and signals completion with a done pulse. It sits between a register/CPU-side requester and the sequence-detection datapath, and owns detector configuration and scheduling.

Parameters:
DATA_W, 16, width of scanned word; number of scan cycles
PAT_MAX, 4, maximum pattern length in bits (>=2)
CNT_W, $clog2(DATA_W+1), width of match counter
POS_W, $clog2(DATA_W), width of bit-position index

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request scan; accepted only when ready=1
abort  in  1  cancel scan in progress
in_word  in  DATA_W  word to scan; sampled on accepted start
cfg_pat  in  PAT_MAX  pattern; LSB is the last bit of the sequence; sampled on accepted start
cfg_len  in  $clog2(PAT_MAX+1)  pattern length; sampled on accepted start
cfg_ovl  in  1  1 = overlapping matches, 0 = non-overlapping; sampled on accepted start
ready  out  1  high in IDLE
busy  out  1  high in SCAN
ser_bit  out  1  bit presented to matcher this cycle (0 outside SCAN)
match  out  1  Mealy match strobe for the current ser_bit (SCAN only)
done  out  1  one-cycle completion pulse
match_cnt  out  CNT_W  number of matches in the last or current scan
any_match  out  1  at least one match found
first_pos  out  POS_W  scan index k of the bit completing the first match; valid when any_match=1

Behaviour:
- Reset (async, any state): state=IDLE; ready=1; busy=0; done=0; match=0; ser_bit=0; match_cnt=0; any_match=0; first_pos=0; history, seen and index registers cleared; shadow config cleared.
- States: IDLE, SCAN, DONE (2-bit encoding).
- IDLE: ready=1. start=1 at an edge -> latch in_word, cfg_pat, cfg_ovl, effective length L = min(cfg_len, PAT_MAX); clear match_cnt, any_match, first_pos, history, seen; k=0; go to SCAN.
- SCAN (exactly DATA_W cycles, k=0..DATA_W-1): ser_bit = word[DATA_W-1-k]. Window w = {hist[PAT_MAX-2:0], ser_bit}. match = (L!=0) & (seen+1 >= L) & (low L bits of w == low L bits of cfg_pat), combinational within the cycle.
- At each SCAN edge: hist <= w; seen <= min(seen+1, PAT_MAX), except seen <= 0 when match=1 and cfg_ovl=0; if match, match_cnt++ and, when any_match=0, first_pos<=k and any_match<=1; k++. At k=DATA_W-1 the next state is DONE.
- DONE: done=1 for one cycle; results stable; next state IDLE. Results hold until the next accepted start.
- Latency: start sampled at edge T -> SCAN during cycles T+1..T+DATA_W -> done high in cycle T+DATA_W+1 -> ready high in cycle T+DATA_W+2.
- start while busy or in DONE: ignored, no effect on the shadow word or config.
- abort in SCAN: return to IDLE at the next edge, no done pulse; match_cnt, any_match and first_pos keep their partial values (including any match in that cycle). abort has no effect in IDLE or DONE. abort and start in the same IDLE cycle: start wins.
- cfg_len=0: no matches; the scan still runs the full DATA_W cycles. cfg_len>PAT_MAX: clamped to PAT_MAX.
- match_cnt cannot overflow (max DATA_W fits in CNT_W). Changing cfg_* inputs during SCAN has no effect.

Test Plan:
- in_word=16'b1010_1000_0000_0101, cfg_pat=4'b0101, cfg_len=3, cfg_ovl=1 -> match at k=2,4,15; match_cnt=3, first_pos=2, any_match=1; done exactly 17 cycles after the start edge.
- Same word and pattern, cfg_ovl=0 -> matches at k=2 and k=15 only; match_cnt=2, first_pos=2.
- in_word=16'hFFFF, cfg_pat=4'b0001, cfg_len=1 -> match every SCAN cycle; match_cnt=16; cfg_len=0 with the same word -> match_cnt=0, any_match=0, done still pulses.
- Start the first test case, assert abort at k=5 -> IDLE next cycle, no done, match_cnt=2, ready=1; a second start pulse at k=3 of a new scan is ignored.
- Assert rst asynchronously mid-SCAN (k=8) -> all outputs at reset values immediately; a new start after rst deasserts runs a full, correct scan.
- cfg_len=7 (>PAT_MAX=4), cfg_pat=4'b1111, in_word=16'hF000 -> L=4; match at k=3 only; match_cnt=1.
